imem_byte_loader: RTL

- Byte-organised instruction memory that sits on the memory side of the fetch stage.
- Accepts 32-bit instruction words on a valid/ready load port and writes each word big-endian into byte storage, one byte per cycle.
- Presents the four consecutive bytes at the fetch PC on memf1..memf4, which the fetch stage concatenates into {memf1,memf2,memf3,memf4}.
- Acts as the writer/responder for the fetch stage's byte-lane read interface.

---
 rtl/imem_byte_loader.sv | 87 ++++++++
 1 files changed

// File: rtl/imem_byte_loader.sv
// imem_byte_loader: byte-wide instruction memory loaded big-endian one byte per cycle from a valid/ready word port
module imem_byte_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              ld_done,
    output logic              busy,
    output logic [CNT_W-1:0]  ld_count,
    input  logic [31:0]       IF_pcs,
    output logic [7:0]        memf1,
    output logic [7:0]        memf2,
    output logic [7:0]        memf3,
    output logic [7:0]        memf4
);
    typedef enum logic [2:0] {IDLE, WB0, WB1, WB2, WB3} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d, wr_en;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] pa;
    logic              pcs_unused;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_en   = state_q != IDLE;
        case (state_q)
            IDLE: if (ld_valid) begin
                state_d = WB0;
                addr_d  = ld_addr;
                data_d  = ld_data;
            end
            WB0: state_d = WB1;
            WB1: state_d = WB2;
            WB2: state_d = WB3;
            default: state_d = IDLE;
        endcase
        // each write consumes the top byte and advances the (wrapping) address
        if (wr_en) begin
            addr_d = addr_q + ADDR_W'(1);
            data_d = {data_q[23:0], 8'h00};
        end
        ready_d = state_d == IDLE;
        busy_d  = state_d != IDLE;
        done_d  = state_q == WB3;
        count_d = count_q + CNT_W'(done_d);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            if (wr_en) mem_q[addr_q] <= data_q[31:24];
        end
    end
    assign pa         = IF_pcs[ADDR_W-1:0];
    assign pcs_unused = ^IF_pcs[31:ADDR_W];
    assign memf1      = mem_q[pa];
    assign memf2      = mem_q[pa + ADDR_W'(1)];
    assign memf3      = mem_q[pa + ADDR_W'(2)];
    assign memf4      = mem_q[pa + ADDR_W'(3)];
    assign ld_ready   = ready_q;
    assign busy       = busy_q;
    assign ld_done    = done_q;
    assign ld_count   = count_q;
endmodule
